lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- HD44780-compatible bus receiver: the LCD-side end of the 4-bit SC1602 character-LCD write interface.
- Samples en/rs/rw/data[3:0], reassembles nibbles into command/data bytes and tracks controller state (interface width, address counter, entry mode, display flags).
- Keeps a 2x16 shadow DDRAM, readable by the bench or other logic.
- Used as an in-FPGA display model for checking LCD drivers, and as a mirror of panel contents for debug.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every bus input (min 2).
- TIMEOUT_CYCLES, 50000, nibble-pair timeout in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- lcd_en  in  1  LCD enable strobe, asynchronous to clk
- lcd_rs  in  1  0=command, 1=data
- lcd_rw  in  1  0=write, 1=read (reads unsupported)
- lcd_data  in  4  data bus DB7..DB4
- rd_addr  in  5  shadow index; 0-15 = line0, 16-31 = line1
- rd_data  out  8  shadow byte, registered
- busy  out  1  clear-fill in progress
- cmd_valid  out  1  1-cycle pulse per completed byte
- cmd_rs  out  1  rs of completed byte
- cmd_byte  out  8  completed byte
- four_bit  out  1  DL=0 active
- two_line  out  1  N flag
- disp_on, cursor_on, blink_on  out  1 each  D/C/B flags
- ac  out  7  DDRAM address counter
- disp_shift  out  6  display shift offset, 0..39
- overrun  out  1  pulse: strobe dropped while busy
- rw_err  out  1  pulse: strobe with rw=1

Behaviour:
- All of en/rs/rw/data pass through SYNC_STAGES flops.
- Strobe = falling edge of synchronized en. rs/rw/data are taken from the last synchronized sample before the fall.
- Strobe detected in cycle N: cmd_valid and all state updates become visible in cycle N+1.
- Reset values:
  - four_bit=0, two_line=0, D=C=B=0, I/D=1, S=0, ac=0, disp_shift=0.
  - nibble phase = high.
  - all pulse outputs 0, rd_data=0.
- State machine:
  - RESET_FILL: entered on reset release, busy=1.
  - IDLE.
  - CLEAR_FILL: busy=1.
- Fill writes 0x20 to one index per cycle, 0 to 31 (32 cycles), then returns to IDLE.
- Strobe with rw=1: rw_err pulses. No state change and no nibble-phase change.
- Strobe while busy: overrun pulses. Strobe dropped, including its nibble, and nibble phase unchanged.
- 8-bit mode (four_bit=0): each strobe forms byte {data,4'h0}.
- 4-bit mode: first strobe latches the high nibble. Second strobe completes {hi,lo}, then phase returns to high.
- Command decode, first matching bit from MSB:
  - 1xxxxxxx: ac = byte[6:0].
  - 01xxxxxx: CGRAM address; ignored apart from cmd_valid.
  - 001DNFxx: four_bit=~D, two_line=N. A switch to 4-bit resets phase to high.
  - 0001SRxx:
    - S=0 moves ac by +1 (R=1) or -1 with wrap.
    - S=1 changes disp_shift by ±1 modulo 40.
  - 00001DCB: sets disp_on, cursor_on, blink_on.
  - 000001IS: sets I/D and S.
  - 0000001x: ac=0, disp_shift=0.
  - 00000001: ac=0, I/D=1, disp_shift=0, enter CLEAR_FILL.
- Data byte (rs=1):
  - Stored only when ac is in 0x00-0x0F (index ac) or 0x40-0x4F (index 16+ac-0x40). Other addresses are not stored.
  - Then ac steps by I/D.
  - When S=1, disp_shift also steps: +1 if I/D=1, else -1.
- ac wrap: increment 0x27→0x40, 0x67→0x00; decrement 0x40→0x27, 0x00→0x67.
- rd_data = shadow[rd_addr] one cycle later. A write and a read of the same index in the same cycle return the old value.
- Asserting resetn low mid-fill or mid-byte aborts immediately. Everything returns to reset values and RESET_FILL restarts.

Optional Feature:
- Macro: LCD_BUS_RECEIVER_TIMEOUT_EN.
- Defined: a counter starts when the high nibble is latched. If no second strobe arrives within TIMEOUT_CYCLES, phase returns to high, the half byte is discarded and overrun pulses once.
- Undefined: no counter; phase waits indefinitely.

Test Plan:
- Reset release → busy=1 for exactly 32 cycles. Reading all 32 indices then returns 0x20; four_bit=0, ac=0.
- Strobes 0x3,0x3,0x3,0x2 (rs=0) → four cmd_valid pulses with cmd_byte 0x30,0x30,0x30,0x20; four_bit=1 after the 4th, phase high.
- 4-bit pairs (2,8),(0,F),(0,6) → two_line=1; disp_on=cursor_on=blink_on=1; cmd_byte 0x28,0x0F,0x06.
- Cmd 0xA7, then data 0x42, then data 0x43 → 0x42 not stored and ac=0x40; 0x43 stored at index 16 and ac=0x41.
- Cmd 0x01, then a strobe 3 cycles later → overrun pulse, byte dropped, busy 32 cycles; afterwards all indices 0x20 and ac=0.
- Strobe with rw=1 between the two nibbles of a data byte → rw_err pulse. The next strobe still completes the byte correctly.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: LCD-side model of the HD44780 4/8-bit write bus with a 2x16 shadow DDRAM.
// Optional nibble-pair timeout is enabled by defining LCD_BUS_RECEIVER_TIMEOUT_EN.
module lcd_bus_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       four_bit,
    output logic       two_line,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] ac,
    output logic [5:0] disp_shift,
    output logic       overrun,
    output logic       rw_err
);
    typedef enum logic [1:0] {RESET_FILL, IDLE, CLEAR_FILL} state_t;

    localparam int unsigned IDX_W  = 5;
    localparam logic [7:0]  BLANK  = 8'h20;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("lcd_bus_receiver: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // Bus synchronizers plus one extra stage holding the sample taken just before en falls
    logic [SYNC_STAGES-1:0]      en_sync, rs_sync, rw_sync;
    logic [SYNC_STAGES-1:0][3:0] data_sync;
    logic                        en_p, rs_p, rw_p;
    logic [3:0]                  data_p;
    logic                        en_s, strobe;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_sync   <= '0;
            rs_sync   <= '0;
            rw_sync   <= '0;
            data_sync <= '0;
            en_p      <= 1'b0;
            rs_p      <= 1'b0;
            rw_p      <= 1'b0;
            data_p    <= 4'h0;
        end else begin
            en_sync   <= {en_sync[SYNC_STAGES-2:0], lcd_en};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
            rw_sync   <= {rw_sync[SYNC_STAGES-2:0], lcd_rw};
            data_sync <= {data_sync[SYNC_STAGES-2:0], lcd_data};
            en_p      <= en_sync[SYNC_STAGES-1];
            rs_p      <= rs_sync[SYNC_STAGES-1];
            rw_p      <= rw_sync[SYNC_STAGES-1];
            data_p    <= data_sync[SYNC_STAGES-1];
        end
    end

    assign en_s   = en_sync[SYNC_STAGES-1];
    assign strobe = en_p & ~en_s;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    endfunction

    function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
        if (up) return (s == 6'd39) ? 6'd0 : s + 6'd1;
        return (s == 6'd0) ? 6'd39 : s - 6'd1;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] fill_q, fill_d;
    logic             phase_hi, phase_hi_d;
    logic [3:0]       hi_nib, hi_nib_d;
    logic             id_q, id_d, s_q, s_d;
    logic             busy_d, cmd_valid_d, cmd_rs_d, overrun_d, rw_err_d;
    logic [7:0]       cmd_byte_d;
    logic             four_bit_d, two_line_d, disp_on_d, cursor_on_d, blink_on_d;
    logic [6:0]       ac_d;
    logic [5:0]       disp_shift_d;
    logic             byte_done;
    logic [7:0]       byte_val;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [7:0]       mem_wdata;

`ifdef LCD_BUS_RECEIVER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt, to_cnt_d;
`endif

    // Next-state: fill sequencing, strobe acceptance, nibble assembly and command decode
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        phase_hi_d   = phase_hi;
        hi_nib_d     = hi_nib;
        id_d         = id_q;
        s_d          = s_q;
        cmd_valid_d  = 1'b0;
        cmd_rs_d     = cmd_rs;
        cmd_byte_d   = cmd_byte;
        overrun_d    = 1'b0;
        rw_err_d     = 1'b0;
        four_bit_d   = four_bit;
        two_line_d   = two_line;
        disp_on_d    = disp_on;
        cursor_on_d  = cursor_on;
        blink_on_d   = blink_on;
        ac_d         = ac;
        disp_shift_d = disp_shift;
        byte_done    = 1'b0;
        byte_val     = 8'h00;
        mem_we       = 1'b0;
        mem_idx      = fill_q;
        mem_wdata    = BLANK;
`ifdef LCD_BUS_RECEIVER_TIMEOUT_EN
        to_cnt_d     = '0;
`endif

        case (state_q)
            RESET_FILL, CLEAR_FILL: begin
                mem_we = 1'b1;
                fill_d = fill_q + IDX_W'(1);
                if (fill_q == IDX_W'(31)) state_d = IDLE;
            end
            default: ;
        endcase

        if (strobe) begin
            if (state_q != IDLE) begin
                overrun_d = 1'b1;
            end else if (rw_p) begin
                rw_err_d = 1'b1;
            end else if (!four_bit) begin
                byte_done = 1'b1;
                byte_val  = {data_p, 4'h0};
            end else if (phase_hi) begin
                hi_nib_d   = data_p;
                phase_hi_d = 1'b0;
            end else begin
                byte_done = 1'b1;
                byte_val  = {hi_nib, data_p};
            end
        end

`ifdef LCD_BUS_RECEIVER_TIMEOUT_EN
        // Abandon a half byte whose low nibble never arrives
        if (!phase_hi) begin
            if (!strobe && to_cnt >= TO_W'(TIMEOUT_CYCLES - 1)) begin
                phase_hi_d = 1'b1;
                overrun_d  = 1'b1;
            end else begin
                to_cnt_d = to_cnt + TO_W'(1);
            end
        end
`endif

        if (byte_done) begin
            phase_hi_d  = 1'b1;
            cmd_valid_d = 1'b1;
            cmd_rs_d    = rs_p;
            cmd_byte_d  = byte_val;
            if (rs_p) begin
                // Only the two visible 16-char windows are mirrored
                if (ac[6:4] == 3'b000 || ac[6:4] == 3'b100) begin
                    mem_we    = 1'b1;
                    mem_idx   = {ac[6], ac[3:0]};
                    mem_wdata = byte_val;
                end
                ac_d = ac_step(ac, id_q);
                if (s_q) disp_shift_d = shift_step(disp_shift, id_q);
            end else begin
                casez (byte_val)
                    8'b1???????: ac_d = byte_val[6:0];
                    8'b01??????: ;
                    8'b001?????: begin
                        four_bit_d = ~byte_val[4];
                        two_line_d = byte_val[3];
                    end
                    8'b0001????: begin
                        if (byte_val[3]) disp_shift_d = shift_step(disp_shift, byte_val[2]);
                        else             ac_d         = ac_step(ac, byte_val[2]);
                    end
                    8'b00001???: begin
                        disp_on_d   = byte_val[2];
                        cursor_on_d = byte_val[1];
                        blink_on_d  = byte_val[0];
                    end
                    8'b000001??: begin
                        id_d = byte_val[1];
                        s_d  = byte_val[0];
                    end
                    8'b0000001?: begin
                        ac_d         = 7'h00;
                        disp_shift_d = 6'd0;
                    end
                    8'b00000001: begin
                        ac_d         = 7'h00;
                        id_d         = 1'b1;
                        disp_shift_d = 6'd0;
                        state_d      = CLEAR_FILL;
                    end
                    default: ;
                endcase
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RESET_FILL;
            fill_q     <= '0;
            phase_hi   <= 1'b1;
            hi_nib     <= 4'h0;
            id_q       <= 1'b1;
            s_q        <= 1'b0;
            busy       <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_rs     <= 1'b0;
            cmd_byte   <= 8'h00;
            overrun    <= 1'b0;
            rw_err     <= 1'b0;
            four_bit   <= 1'b0;
            two_line   <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            ac         <= 7'h00;
            disp_shift <= 6'd0;
`ifdef LCD_BUS_RECEIVER_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            phase_hi   <= phase_hi_d;
            hi_nib     <= hi_nib_d;
            id_q       <= id_d;
            s_q        <= s_d;
            busy       <= busy_d;
            cmd_valid  <= cmd_valid_d;
            cmd_rs     <= cmd_rs_d;
            cmd_byte   <= cmd_byte_d;
            overrun    <= overrun_d;
            rw_err     <= rw_err_d;
            four_bit   <= four_bit_d;
            two_line   <= two_line_d;
            disp_on    <= disp_on_d;
            cursor_on  <= cursor_on_d;
            blink_on   <= blink_on_d;
            ac         <= ac_d;
            disp_shift <= disp_shift_d;
`ifdef LCD_BUS_RECEIVER_TIMEOUT_EN
            to_cnt     <= to_cnt_d;
`endif
        end
    end

    // Shadow DDRAM; contents are rebuilt by the fill after every reset
    logic [7:0] mem [32];

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rd_data <= 8'h00;
        else         rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: scoreboard bench driving the LCD bus and checking completed bytes, flags and shadow RAM.
module tb_lcd_bus_receiver;
    logic       clk = 1'b0;
    logic       resetn;
    logic       lcd_en, lcd_rs, lcd_rw;
    logic [3:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, cmd_valid, cmd_rs;
    logic [7:0] cmd_byte;
    logic       four_bit, two_line, disp_on, cursor_on, blink_on;
    logic [6:0] ac;
    logic [5:0] disp_shift;
    logic       overrun, rw_err;

    always #5 clk = ~clk;

    lcd_bus_receiver dut (
        .clk        (clk),
        .resetn     (resetn),
        .lcd_en     (lcd_en),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .cmd_rs     (cmd_rs),
        .cmd_byte   (cmd_byte),
        .four_bit   (four_bit),
        .two_line   (two_line),
        .disp_on    (disp_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .ac         (ac),
        .disp_shift (disp_shift),
        .overrun    (overrun),
        .rw_err     (rw_err)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] sb_exp;
    int         busy_runs[$];
    int         run_len = 0;
    int         ov_cnt  = 0;
    int         rwe_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops, pulse counting, busy run lengths
    always @(negedge clk) begin
        if (resetn) begin
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check("cmd_unexpected", 32'({cmd_rs, cmd_byte}), 32'h1ff);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("cmd_byte", 32'({cmd_rs, cmd_byte}), 32'(sb_exp));
                end
            end
            if (overrun) ov_cnt++;
            if (rw_err)  rwe_cnt++;
            if (busy) begin
                run_len++;
            end else if (run_len != 0) begin
                busy_runs.push_back(run_len);
                run_len = 0;
            end
        end
    end

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
        @(posedge clk); #2;
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_en   = 1'b1;
        repeat (4) @(posedge clk);
        #2 lcd_en = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic send8(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
        strobe(rs, 1'b0, b[7:4]);
    endtask

    task automatic send4(input logic rs, input logic [7:0] b);
        strobe(rs, 1'b0, b[7:4]);
        exp_q.push_back({rs, b});
        strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [7:0] e, input string tag);
        @(posedge clk); #2 rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_stuck", 32'(busy), 32'h0);
        @(negedge clk);
    endtask

    task automatic check_busy_run(input string tag);
        if (busy_runs.size() == 0) check(tag, 32'h0, 32'd32);
        else                       check(tag, 32'(busy_runs.pop_front()), 32'd32);
    endtask

    initial begin
        resetn   = 1'b0;
        lcd_en   = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_data = 4'h0;
        rd_addr  = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      32'(busy),       32'h1);
        check("rst_four_bit",  32'(four_bit),   32'h0);
        check("rst_two_line",  32'(two_line),   32'h0);
        check("rst_disp_on",   32'(disp_on),    32'h0);
        check("rst_ac",        32'(ac),         32'h0);
        check("rst_shift",     32'(disp_shift), 32'h0);
        check("rst_cmd_valid", 32'(cmd_valid),  32'h0);
        check("rst_rd_data",   32'(rd_data),    32'h0);

        @(posedge clk); #2 resetn = 1'b1;
        wait_idle();
        check_busy_run("reset_busy_len");
        check("post_rst_four_bit", 32'(four_bit), 32'h0);
        check("post_rst_ac",       32'(ac),       32'h0);
        for (int i = 0; i < 32; i++) rd_chk(5'(i), 8'h20, "reset_fill");

        // Power-on wake-up sequence and switch to 4-bit mode
        send8(1'b0, 8'h30);
        send8(1'b0, 8'h30);
        send8(1'b0, 8'h30);
        @(negedge clk);
        check("still_8bit", 32'(four_bit), 32'h0);
        send8(1'b0, 8'h20);
        @(negedge clk);
        check("four_bit_on", 32'(four_bit), 32'h1);

        send4(1'b0, 8'h28);
        @(negedge clk);
        check("two_line", 32'(two_line), 32'h1);
        send4(1'b0, 8'h0F);
        send4(1'b0, 8'h06);
        @(negedge clk);
        check("disp_on",   32'(disp_on),   32'h1);
        check("cursor_on", 32'(cursor_on), 32'h1);
        check("blink_on",  32'(blink_on),  32'h1);

        // Unmapped address, then wrap into line 1
        send4(1'b0, 8'hA7);
        @(negedge clk);
        check("ac_set", 32'(ac), 32'h27);
        send4(1'b1, 8'h42);
        @(negedge clk);
        check("ac_wrap_up", 32'(ac), 32'h40);
        rd_chk(5'd16, 8'h20, "no_store_16");
        rd_chk(5'd7,  8'h20, "no_store_7");
        send4(1'b1, 8'h43);
        @(negedge clk);
        check("ac_after_43", 32'(ac), 32'h41);
        rd_chk(5'd16, 8'h43, "store_16");

        // Read strobe between the two nibbles of a data byte
        strobe(1'b1, 1'b0, 4'h4);
        strobe(1'b0, 1'b1, 4'h0);
        exp_q.push_back({1'b1, 8'h45});
        strobe(1'b1, 1'b0, 4'h5);
        @(negedge clk);
        check("rw_err_cnt", 32'(rwe_cnt), 32'd1);
        check("ac_after_45", 32'(ac), 32'h42);
        rd_chk(5'd17, 8'h45, "store_17");

        // Display shift modulo 40 and address decrement wrap
        send4(1'b0, 8'h1C);
        @(negedge clk);
        check("shift_inc", 32'(disp_shift), 32'd1);
        send4(1'b0, 8'h18);
        send4(1'b0, 8'h18);
        @(negedge clk);
        check("shift_wrap", 32'(disp_shift), 32'd39);
        send4(1'b0, 8'h80);
        send4(1'b0, 8'h10);
        @(negedge clk);
        check("ac_wrap_down", 32'(ac), 32'h67);

        // Clear display, with a strobe landing during the fill
        send4(1'b0, 8'h01);
        strobe(1'b0, 1'b0, 4'h4);
        wait_idle();
        check_busy_run("clear_busy_len");
        check("overrun_cnt",   32'(ov_cnt),     32'd1);
        check("clear_ac",      32'(ac),         32'h0);
        check("clear_shift",   32'(disp_shift), 32'h0);
        for (int i = 0; i < 32; i++) rd_chk(5'(i), 8'h20, "clear_fill");

        send4(1'b1, 8'h48);
        @(negedge clk);
        check("ac_after_48", 32'(ac), 32'h1);
        rd_chk(5'd0, 8'h48, "store_0");

        repeat (4) @(negedge clk);
        check("sb_empty",        32'(exp_q.size()), 32'd0);
        check("rw_err_cnt_end",  32'(rwe_cnt),      32'd1);
        check("overrun_cnt_end", 32'(ov_cnt),       32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
